uart_rx: RTL and testbench

- UART receiver for the 8N1 serial frame produced by the FSM transmitter: idle high, one start bit (0), data bits LSB first, one stop bit (1).
- Oversamples the line on an external tick `ena`, from the same baud-generator style as the transmitter, and samples each bit at its centre.
- Presents each received byte with a one-cycle valid strobe, plus framing-error and overrun flags.
- Sits between the pad and the consumer logic (loopback with the transmitter, or downstream FSM).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default frame geometry.
// Used by both the receiver and the transmitter FSMs.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to the idle (high) level.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Metastability filter chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1-style UART receiver with centre sampling, framing-error and overrun flags.
// A line held low after a bad stop bit (break) is not taken as a new start until it returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_err,
  output logic                 overrun,
  input  logic                 ack,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rxs_s;
  uart_state_e          state_r, state_next_s;
  logic [TW-1:0]        tcnt_r, tcnt_next_s;
  logic [BW-1:0]        bcnt_r, bcnt_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 armed_r, armed_next_s;
  logic                 valid_set_s;
  logic                 ferr_set_s;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 ferr_r;
  logic                 overrun_r;
  logic                 pending_r;
  logic                 busy_r;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs_s)
  );

  // Next-state, counters and shift register; only ena ticks advance the frame
  always_comb begin
    state_next_s = state_r;
    tcnt_next_s  = tcnt_r;
    bcnt_next_s  = bcnt_r;
    shift_next_s = shift_r;
    armed_next_s = armed_r | (rxs_s == IDLE_LEVEL);
    valid_set_s  = 1'b0;
    ferr_set_s   = 1'b0;
    if (ena) begin
      case (state_r)
        IDLE: begin
          if (armed_r && (rxs_s == START_LEVEL)) begin
            state_next_s = START;
            tcnt_next_s  = '0;
          end else begin
            state_next_s = IDLE;
          end
        end
        START: begin
          if (tcnt_r == T_HALF) begin
            tcnt_next_s = '0;
            bcnt_next_s = '0;
            if (rxs_s == START_LEVEL) begin
              state_next_s = DATA;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            tcnt_next_s = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        DATA: begin
          if (tcnt_r == T_FULL) begin
            shift_next_s = {rxs_s, shift_r[DATA_BITS-1:1]};
            tcnt_next_s  = '0;
            if (bcnt_r == B_LAST) begin
              bcnt_next_s  = '0;
              state_next_s = STOP;
            end else begin
              bcnt_next_s = bcnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
          end else begin
            tcnt_next_s = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        STOP: begin
          if (tcnt_r == T_FULL) begin
            tcnt_next_s  = '0;
            state_next_s = IDLE;
            armed_next_s = (rxs_s == IDLE_LEVEL);
            if (rxs_s == IDLE_LEVEL) begin
              valid_set_s = 1'b1;
            end else begin
              ferr_set_s = 1'b1;
            end
          end else begin
            tcnt_next_s = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_next_s = IDLE;
          tcnt_next_s  = '0;
          bcnt_next_s  = '0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tcnt_r  <= '0;
      bcnt_r  <= '0;
      shift_r <= '0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      tcnt_r  <= tcnt_next_s;
      bcnt_r  <= bcnt_next_s;
      shift_r <= shift_next_s;
      armed_r <= armed_next_s;
    end
  end

  // Registered outputs; an ack coinciding with valid leaves the new byte pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      overrun_r <= 1'b0;
      pending_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      valid_r <= valid_set_s;
      ferr_r  <= ferr_set_s;
      busy_r  <= (state_next_s != IDLE);
      if (valid_set_s) begin
        data_r <= shift_r;
      end
      if (valid_r) begin
        pending_r <= 1'b1;
        if (ack) begin
          overrun_r <= 1'b0;
        end else if (pending_r) begin
          overrun_r <= 1'b1;
        end
      end else if (ack) begin
        pending_r <= 1'b0;
        overrun_r <= 1'b0;
      end
    end
  end

  assign data        = data_r;
  assign valid       = valid_r;
  assign framing_err = ferr_r;
  assign overrun     = overrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// against a transaction-level model of received data, pending and overrun.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          rx  = 1'b1;
  logic          ack = 1'b0;
  logic [DB-1:0] data;
  logic          valid;
  logic          framing_err;
  logic          overrun;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int ena_period = 1;
  int ena_cnt    = 0;

  // Reference model state
  logic [DB-1:0] exp_data = '0;
  bit            exp_pend = 1'b0;
  bit            exp_ovr  = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .overrun     (overrun),
    .ack         (ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Oversample tick generator, updated away from the active edge
  always @(negedge clk) begin
    if (ena_cnt >= ena_period - 1) begin
      ena_cnt = 0;
      ena = 1'b1;
    end else begin
      ena_cnt = ena_cnt + 1;
      ena = 1'b0;
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt = valid_cnt + 1;
    if (framing_err === 1'b1) ferr_cnt = ferr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (ena) c = c + 1;
    end
    #1;
  endtask

  task automatic pulse_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    exp_pend = 1'b0;
    exp_ovr  = 1'b0;
    @(negedge clk);
    check_val("overrun_after_ack", {31'd0, overrun}, {31'd0, exp_ovr});
  endtask

  task automatic do_frame(input logic [DB-1:0] b, input bit stop, input bit do_ack, input int hold_low);
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = stop;
    wait_ticks(OS);
    if (hold_low > 0) begin
      rx = 1'b0;
      wait_ticks(hold_low);
      check_val("break_busy", {31'd0, busy}, 32'd0);
      check_val("break_valid", valid_cnt - v0, 32'd0);
    end
    rx = 1'b1;
    wait_ticks(4);
    repeat (3) @(negedge clk);
    if (stop) begin
      if (exp_pend) exp_ovr = 1'b1;
      exp_pend = 1'b1;
      exp_data = b;
    end
    check_val("valid_pulses", valid_cnt - v0, stop ? 32'd1 : 32'd0);
    check_val("ferr_pulses", ferr_cnt - f0, stop ? 32'd0 : 32'd1);
    check_val("data", {24'd0, data}, {24'd0, exp_data});
    check_val("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    check_val("busy_idle", {31'd0, busy}, 32'd0);
    if (do_ack) pulse_ack();
  endtask

  initial begin
    int v0;
    int f0;
    // Reset state
    #1;
    check_val("rst_data", {24'd0, data}, 32'd0);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_ferr", {31'd0, framing_err}, 32'd0);
    check_val("rst_overrun", {31'd0, overrun}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);

    // Nominal frame with ack
    do_frame(8'h55, 1'b1, 1'b1, 0);

    // Start-bit glitch
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_ticks(4);
    check_val("glitch_busy_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_ticks(OS);
    check_val("glitch_busy_low", {31'd0, busy}, 32'd0);
    check_val("glitch_valid", valid_cnt - v0, 32'd0);
    check_val("glitch_ferr", ferr_cnt - f0, 32'd0);

    // Framing error followed by a held-low break
    do_frame(8'hA3, 1'b0, 1'b0, 3 * OS);

    // Back-to-back frames without ack, then ack clears overrun
    do_frame(8'h01, 1'b1, 1'b0, 0);
    do_frame(8'hFF, 1'b1, 1'b1, 0);

    // Reset during bit 4 of 0x3C
    v0 = valid_cnt;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h3C >> i);
      wait_ticks(OS);
    end
    rx = 1'(8'h3C >> 4);
    wait_ticks(OS / 2);
    rst = 1'b1;
    #1;
    check_val("midrst_data", {24'd0, data}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_overrun", {31'd0, overrun}, 32'd0);
    check_val("midrst_valid", {31'd0, valid}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    exp_pend = 1'b0;
    exp_ovr  = 1'b0;
    wait_ticks(4 * OS);
    check_val("midrst_no_valid", valid_cnt - v0, 32'd0);
    do_frame(8'h3C, 1'b1, 1'b1, 0);

    // Slow tick: ena every third clock
    ena_period = 3;
    wait_ticks(2);
    do_frame(8'h80, 1'b1, 1'b1, 0);

    // Randomized frames
    for (int n = 0; n < 20; n++) begin
      logic [DB-1:0] b;
      bit stop;
      bit a;
      ena_period = $urandom_range(1, 3);
      wait_ticks(2);
      b = DB'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      a = $urandom_range(0, 1) == 1;
      do_frame(b, stop, a, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
